wb_ofmap_write_arbiter: RTL
===========================

// Module: wb_ofmap_write_arbiter
// PURPOSE
//  Collects the two conv writeback result ports and merges them into the single write port of
//  the output-feature-map SRAM. Port 0 and port 1 carry output rows in the fixed 0/1, 2/3, 4 pattern.
//  The block buffers each port in its own FIFO and generates the SRAM address (row*DEPTH+col).
//  It round-robin arbitrates the one SRAM write per cycle and reports done/overflow to the layer sequencer.
// PARAMETERS
//  DATA_W   25  width of result data
//  DEPTH    61  beats (columns) per output row
//  FIFO_D   4   entries per port FIFO (power of 2)
//  ADDR_W   12  SRAM address width
// PORTS
//  clk        in   1       clock
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       pulse: begin a 5-row group; samples base_addr
//  base_addr  in   ADDR_W  SRAM address of row 0, col 0 of this group
//  p0_valid   in   1       port 0 beat valid (no ready; block must absorb or flag)
//  p0_data    in   DATA_W  port 0 beat
//  p1_valid   in   1       port 1 beat valid
//  p1_data    in   DATA_W  port 1 beat
//  mem_ready  in   1       SRAM accepts write this cycle
//  mem_we     out  1       SRAM write request (registered)
//  mem_addr   out  ADDR_W  SRAM write address (registered)
//  mem_wdata  out  DATA_W  SRAM write data (registered)
//  busy       out  1       group in progress (state != IDLE)
//  done       out  1       1-cycle pulse: all 5*DEPTH writes completed
//  overflow   out  1       sticky: a beat was dropped; cleared by start
// BEHAVIOUR
//  Reset: state=IDLE, FIFOs empty, col/phase counters 0, rr pointer->port0, all outputs 0.
//  FSM: IDLE -start-> RUN. RUN -(phase C complete)-> DRAIN. DRAIN -(FIFOs empty and last write done)-> DONE.
//   DONE -> IDLE (done=1 for exactly this cycle). start is ignored outside IDLE.
//  Phases in RUN: A: p0->row0, p1->row1. B: p0->row2, p1->row3. C: p0->row4; p1 not expected.
//   Each port has a col counter 0..DEPTH-1. An accepted beat pushes {data, base+row*DEPTH+col}.
//   A port that finishes DEPTH beats stops accepting. Phase advances, and both col counters clear,
//   on the cycle the last active port pushes beat DEPTH-1.
//   Address arithmetic is ADDR_W bits, wraps modulo 2^ADDR_W with no flag.
//  Drop and overflow rules: set overflow and drop the beat when
//   - its FIFO is full,
//   - it arrives on a port that has finished its phase quota,
//   - p1 fires in phase C.
//   Valid beats in IDLE/DRAIN/DONE are dropped silently and do not set overflow.
//   A same-cycle push+pop on a full FIFO is accepted.
//  Output stage: while mem_we=1 and mem_ready=0, hold mem_we/addr/wdata stable.
//   A write completes on mem_we&mem_ready. The stage reloads from a FIFO the same cycle
//   (full throughput, 1 write/cycle).
//  Arbitration: when both FIFOs are non-empty, grant the port not granted last. Pointer updates on pop only.
//   When one FIFO is non-empty, grant it.
//  Latency: beat accepted in cycle t with empty FIFOs and idle output stage -> mem_we=1 at t+1.
//  Completion: exactly 5*DEPTH completed writes per group, then DONE. done pulses 1 cycle after the last completion.
//  Reset mid-group: asynchronous abort; everything returns to reset values and no done is issued.
// TESTING
//  1. base=100, mem_ready=1, p0/p1 valid every cycle for phases A,B, p0 only for C
//     -> 305 writes; row1 col0 at 161; row4 col60 at 404; done once; overflow=0.
//  2. Both FIFOs non-empty, mem_ready=1 -> writes alternate p0,p1,p0,... starting with p0 after reset.
//  3. mem_ready held 0 for 10 cycles while both ports stream
//     -> mem_* stable while stalled; overflow=1 after 4 stalled beats; done still fires.
//  4. p1_valid pulsed in phase C, and p0 given 62 beats in phase A
//     -> overflow=1, extra beats never written, address sequence unchanged.
//  5. start while busy is ignored. start in IDLE clears overflow.
//  6. Reset asserted mid-phase B -> all outputs 0 next edge; a new start gives a clean 305-write group.

Source files
------------

// File: rtl/wb_ofmap_write_arbiter.sv
// Merges the two conv writeback ports into the single ofmap SRAM write port.
// Each port has its own small FIFO; one SRAM write per cycle, granted round-robin.
//
// state  | meaning
// IDLE   | waiting for start; beats dropped silently
// RUN    | accepting beats for phases A/B/C (rows 0/1, 2/3, 4)
// DRAIN  | all 5*DEPTH beats accepted; emptying FIFOs and output stage
// DONE   | last write completed; done pulses for this one cycle
module wb_ofmap_write_arbiter #(
    parameter int DATA_W = 25,
    parameter int DEPTH  = 61,
    parameter int FIFO_D = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              p0_valid,
    input  logic [DATA_W-1:0] p0_data,
    input  logic              p1_valid,
    input  logic [DATA_W-1:0] p1_data,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int COL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_D);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + ADDR_W;
    localparam int TOTAL = 5 * DEPTH;
    localparam int WR_W  = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nx;

    logic [1:0]        phase;
    logic [COL_W-1:0]  col0, col1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [WR_W-1:0]   wr_left;
    logic              rr;

    logic [ENT_W-1:0]  fifo_mem [2][FIFO_D];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [CNT_W-1:0]  cnt [2];
    logic [ENT_W-1:0]  in_ent [2];
    logic [ENT_W-1:0]  head [2];

    logic       run, grp_start, stage_free, wr_done;
    logic [1:0] want, empty, full, avail, pop, push, store, pop_fifo;
    logic       last0, last1, fin0, fin1, advance, drop;
    logic [ENT_W-1:0] stage_ent;

    assign run       = (state == S_RUN);
    assign grp_start = (state == S_IDLE) && start;
    assign wr_done   = mem_we && mem_ready;
    assign stage_free = !mem_we || mem_ready;

    assign in_ent[0] = {p0_data, addr0};
    assign in_ent[1] = {p1_data, addr1};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            empty[i] = (cnt[i] == '0);
            full[i]  = (cnt[i] == CNT_W'(FIFO_D));
            head[i]  = fifo_mem[i][rd_ptr[i]];
        end
    end

    assign want[0] = run && p0_valid && (col0 != COL_W'(DEPTH));
    assign want[1] = run && p1_valid && (phase != 2'd2) && (col1 != COL_W'(DEPTH));

    // An arriving beat counts as available so an empty FIFO can be bypassed.
    assign avail = ~empty | want;

    always_comb begin
        pop = 2'b00;
        if (stage_free) begin
            if (avail == 2'b11)
                pop[rr] = 1'b1;
            else
                pop = avail;
        end
    end

    assign push     = want & (~full | pop);
    assign store    = push & ~(empty & pop);
    assign pop_fifo = pop & ~empty;

    assign stage_ent = pop[0] ? (empty[0] ? in_ent[0] : head[0])
                              : (empty[1] ? in_ent[1] : head[1]);

    assign last0   = push[0] && (col0 == COL_W'(DEPTH - 1));
    assign last1   = push[1] && (col1 == COL_W'(DEPTH - 1));
    assign fin0    = (col0 == COL_W'(DEPTH)) || last0;
    assign fin1    = (phase == 2'd2) || (col1 == COL_W'(DEPTH)) || last1;
    assign advance = run && fin0 && fin1 && (last0 || last1);

    assign drop = run && ((p0_valid && !push[0]) || (p1_valid && !push[1]));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (advance && (phase == 2'd2)) state_nx = S_DRAIN;
            S_DRAIN: if (wr_done && (wr_left == WR_W'(1))) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= '0;
            col0     <= '0;
            col1     <= '0;
            addr0    <= '0;
            addr1    <= '0;
            wr_left  <= '0;
            overflow <= 1'b0;
        end else if (grp_start) begin
            phase    <= '0;
            col0     <= '0;
            col1     <= '0;
            addr0    <= base_addr;
            addr1    <= base_addr + ADDR_W'(DEPTH);
            wr_left  <= WR_W'(TOTAL);
            overflow <= 1'b0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            // Row pointers sit one past their row end; skipping DEPTH lands on the next row pair.
            if (advance) begin
                phase <= phase + 2'd1;
                col0  <= '0;
                col1  <= '0;
                addr0 <= addr0 + ADDR_W'(push[0]) + ADDR_W'(DEPTH);
                addr1 <= addr1 + ADDR_W'(push[1]) + ADDR_W'(DEPTH);
            end else begin
                if (push[0]) begin
                    col0  <= col0 + COL_W'(1);
                    addr0 <= addr0 + ADDR_W'(1);
                end
                if (push[1]) begin
                    col1  <= col1 + COL_W'(1);
                    addr1 <= addr1 + ADDR_W'(1);
                end
            end
            if (wr_done && (wr_left != '0))
                wr_left <= wr_left - WR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rr        <= 1'b0;
        end else if (pop != 2'b00) begin
            mem_we                <= 1'b1;
            {mem_wdata, mem_addr} <= stage_ent;
            rr                    <= pop[0];
        end else if (mem_ready) begin
            mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (store[i])
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop_fifo[i])
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (store[i] && !pop_fifo[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (!store[i] && pop_fifo[i])
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (store[i])
                fifo_mem[i][wr_ptr[i]] <= in_ent[i];
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
